// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared mult/div state encoding, register-zero and MIPS funct constants.
package hazard_ctrl_pkg;
    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} md_state_e;
    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic is_md_start(input logic [5:0] funct);
        return funct == FUNCT_MULT || funct == FUNCT_MULTU || funct == FUNCT_DIV || funct == FUNCT_DIVU;
    endfunction

    function automatic logic is_md_read(input logic [5:0] funct);
        return funct == FUNCT_MFHI || funct == FUNCT_MFLO;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if;
    logic [4:0] ID_rs, ID_rt, EX_rt;
    logic ID_useRs, ID_useRt, EX_memRead, ID_branchTaken, ID_jump, ID_mdStart, ID_mdRead;
    logic pc_sleep, IF_ID_sleep, IF_ID_nop, ID_EX_nop, md_busy, md_go;
    modport master (
        output ID_rs, ID_rt, EX_rt, ID_useRs, ID_useRt, EX_memRead, ID_branchTaken, ID_jump, ID_mdStart, ID_mdRead,
        input  pc_sleep, IF_ID_sleep, IF_ID_nop, ID_EX_nop, md_busy, md_go
    );
    modport slave (
        input  ID_rs, ID_rt, EX_rt, ID_useRs, ID_useRt, EX_memRead, ID_branchTaken, ID_jump, ID_mdStart, ID_mdRead,
        output pc_sleep, IF_ID_sleep, IF_ID_nop, ID_EX_nop, md_busy, md_go
    );
endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// md_busy_timer: RUN/MD_BUSY state plus down-counter; busy lasts MD_LATENCY cycles per accepted start.
module md_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);
    md_state_e        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == RUN) begin
            if (start) begin
                state <= MD_BUSY;
                cnt   <= CNT_W'(MD_LATENCY - 1);
            end
        end else if (cnt == '0) begin
            state <= RUN;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = state == MD_BUSY;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / mult-div stall and branch/jump flush control beside the ID stage.
// Define HAZARD_STATS_EN to add saturating stall_cycles / flush_count outputs.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    logic busy, load_hz, md_hz, stall, flush, go;

    md_busy_timer #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .start(go),
        .busy (busy)
    );

    // All controls are forced low while reset is held.
    always_comb begin
        load_hz = hz.EX_memRead && hz.EX_rt != REG_ZERO &&
                  ((hz.ID_useRs && hz.EX_rt == hz.ID_rs) || (hz.ID_useRt && hz.EX_rt == hz.ID_rt));
        md_hz   = busy && (hz.ID_mdRead || hz.ID_mdStart);
        stall   = !rst && (load_hz || md_hz);
        flush   = !rst && !stall && (hz.ID_branchTaken || hz.ID_jump);
        go      = !rst && !busy && hz.ID_mdStart && !load_hz;
        hz.pc_sleep    = stall;
        hz.IF_ID_sleep = stall;
        hz.ID_EX_nop   = stall;
        hz.IF_ID_nop   = flush;
        hz.md_busy     = !rst && busy;
        hz.md_go       = go;
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
            if (flush && !(&flush_count)) flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven hazard vectors plus mult/div, flush-priority and reset sequences.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    // exp bits: {pc_sleep, IF_ID_sleep, IF_ID_nop, ID_EX_nop, md_busy, md_go}
    typedef struct {
        string      name;
        logic [4:0] rs, rt, ex_rt;
        logic       use_rs, use_rt, mem_rd, br, jmp, md_st, md_rd;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] ST = 6'b110100;
    localparam logic [5:0] FL = 6'b001000;
    localparam logic [5:0] GO = 6'b000001;
    localparam logic [5:0] BS = 6'b000010;
    localparam logic [5:0] BT = 6'b110110;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[12];

    function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic use_rs, input logic use_rt, input logic mem_rd,
                                input logic [4:0] ex_rt, input logic br, input logic jmp,
                                input logic md_st, input logic md_rd, input logic [5:0] exp);
        vec_t v;
        v.name = nm; v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt;
        v.mem_rd = mem_rd; v.ex_rt = ex_rt; v.br = br; v.jmp = jmp;
        v.md_st = md_st; v.md_rd = md_rd; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t ctl(input string nm, input logic br, input logic md_st,
                                 input logic md_rd, input logic [5:0] exp);
        return mk(nm, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, br, 1'b0, md_st, md_rd, exp);
    endfunction

    task automatic drive(input vec_t v);
        hz.ID_rs = v.rs; hz.ID_rt = v.rt; hz.ID_useRs = v.use_rs; hz.ID_useRt = v.use_rt;
        hz.EX_memRead = v.mem_rd; hz.EX_rt = v.ex_rt; hz.ID_branchTaken = v.br;
        hz.ID_jump = v.jmp; hz.ID_mdStart = v.md_st; hz.ID_mdRead = v.md_rd;
    endtask

    task automatic check(input string nm, input logic [5:0] exp);
        logic [5:0] got;
        @(negedge clk);
        got = {hz.pc_sleep, hz.IF_ID_sleep, hz.IF_ID_nop, hz.ID_EX_nop, hz.md_busy, hz.md_go};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic cyc(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        check(v.name, v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = ctl("idle", 1'b0, 1'b0, 1'b0, Z);
        tbl[1]  = mk("load_rs", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ST);
        tbl[2]  = mk("load_r0", 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, Z);
        tbl[3]  = mk("rt_unused", 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, Z);
        tbl[4]  = mk("load_rt", 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, ST);
        tbl[5]  = mk("no_load", 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, Z);
        tbl[6]  = ctl("branch", 1'b1, 1'b0, 1'b0, FL);
        tbl[7]  = mk("jump", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FL);
        tbl[8]  = mk("branch_load", 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, ST);
        tbl[9]  = mk("mdstart_load", 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, ST);
        tbl[10] = ctl("mdread_idle", 1'b0, 1'b0, 1'b1, Z);
        tbl[11] = mk("rs_unused", 5'd4, 5'd2, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, Z);

        // Hazard present while reset held: outputs must stay low.
        drive(tbl[1]);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        check("reset_hold", Z);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(tbl[0]);
        check("post_reset", Z);

        for (int i = 0; i < 12; i++) cyc(tbl[i]);

        // Load-use bubble lasts one cycle once the load leaves EX.
        cyc(mk("lu_stall", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ST));
        cyc(mk("lu_release", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, Z));

        // Stall wins over flush; flush follows once the stall clears.
        cyc(mk("br_stalled", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, ST));
        cyc(mk("br_flush", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, FL));

        // mult then mfhi at cycle 2: busy 1..4, read held 2..4, released 5.
        cyc(ctl("md_c0_go", 1'b0, 1'b1, 1'b0, GO));
        cyc(ctl("md_c1_busy", 1'b0, 1'b0, 1'b0, BS));
        cyc(ctl("md_c2_rd", 1'b0, 1'b0, 1'b1, BT));
        cyc(ctl("md_c3_rd", 1'b0, 1'b0, 1'b1, BT));
        cyc(ctl("md_c4_rd", 1'b0, 1'b0, 1'b1, BT));
        cyc(ctl("md_c5_rel", 1'b0, 1'b0, 1'b1, Z));

        // Back-to-back mult: second start waits out the full busy window.
        cyc(ctl("b2b_go1", 1'b0, 1'b1, 1'b0, GO));
        for (int i = 0; i < 4; i++) cyc(ctl("b2b_wait", 1'b0, 1'b1, 1'b0, BT));
        cyc(ctl("b2b_go2", 1'b0, 1'b1, 1'b0, GO));
        for (int i = 0; i < 4; i++) cyc(ctl("b2b_busy2", 1'b0, 1'b0, 1'b0, BS));
        cyc(ctl("b2b_done", 1'b0, 1'b0, 1'b0, Z));

        // Reset during MD_BUSY discards the operation.
        cyc(ctl("rst_go", 1'b0, 1'b1, 1'b0, GO));
        cyc(ctl("rst_busy1", 1'b0, 1'b0, 1'b0, BS));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(ctl("", 1'b1, 1'b1, 1'b1, Z));
        check("rst_mid_hold", Z);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(tbl[0]);
        check("rst_after", Z);
        cyc(ctl("rst_fresh_go", 1'b0, 1'b1, 1'b0, GO));
        for (int i = 0; i < 4; i++) cyc(ctl("rst_fresh_busy", 1'b0, 1'b0, 1'b0, BS));
        cyc(ctl("rst_fresh_done", 1'b0, 1'b0, 1'b0, Z));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
